// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: single-bus CPU datapath that sequences its own ALU instructions.
// It contains the register file, the Y/Z/HI/LO registers, the ALU and one shared
// internal bus. A micro-step sequencer runs Ra <- Rb op Rc/imm using a start/busy/done
// handshake.
//
// Optional feature, controlled by the macro R0_ZERO_EN:
//   - defined:   R0 always reads as zero, and every write to R0 is discarded.
//   - undefined: R0 behaves as an ordinary register.
//
// Handshake: start is sampled only while the sequencer is IDLE (busy=0).
//   - A start seen while busy is dropped. It is never queued.
//   - done (and err, on an illegal op) is a one-cycle pulse during the last
//     sequencer state. The earliest next start is the cycle after done.
//   - ld_en is honoured only while busy=0.
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  input  logic [DATA_W-1:0] imm,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_n,
  output logic [DATA_W-1:0] bus_q
);

  localparam int SH_W = $clog2(DATA_W);

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHL  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_MUL  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_ADDI = 5'd8;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

  // The sequencer state is kept visible under this name so checkers can bind to it.
  state_t state, state_nx;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   y_q;
  logic [2*DATA_W-1:0] z_q;
  logic [2*DATA_W-1:0] alu_out;
  logic [2*DATA_W-1:0] mul_a, mul_b;
  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   rb_val, rc_val;
  logic [4:0]          op_q;
  logic [REG_AW-1:0]   ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]   imm_q;
  logic                illegal, is_mul, ld_ok, wb_ok;

  assign illegal = (op_q > OP_ADDI);
  assign is_mul  = (op_q == OP_MUL);
  assign busy    = (state != S_IDLE);
  assign bus_q   = bus;

  // Register reads. R0 is forced to zero only when the feature is enabled.
  assign rd_data = (R0_ZERO && rd_addr == '0) ? '0 : regs[rd_addr];
  assign rb_val  = (R0_ZERO && rb_q == '0)    ? '0 : regs[rb_q];
  assign rc_val  = (R0_ZERO && rc_q == '0)    ? '0 : regs[rc_q];
  assign ld_ok   = !(R0_ZERO && ld_addr == '0);
  assign wb_ok   = !(R0_ZERO && ra_q == '0);

  // The shared bus source is selected by the current micro-step.
  always_comb begin
    bus = '0;
    case (state)
      S_T1:    bus = rb_val;
      S_T2:    bus = (op_q == OP_ADDI) ? imm_q : rc_val;
      S_T3:    bus = z_q[DATA_W-1:0];
      S_T4:    bus = z_q[2*DATA_W-1:DATA_W];
      default: bus = '0;
    endcase
  end

  // ALU: Y combined with the bus. The signed multiply sign-extends both operands to 2*DATA_W.
  always_comb begin
    alu_out = '0;
    mul_a   = {{DATA_W{y_q[DATA_W-1]}}, y_q};
    mul_b   = {{DATA_W{bus[DATA_W-1]}}, bus};
    case (op_q)
      OP_ADD:  alu_out = {{DATA_W{1'b0}}, y_q + bus};
      OP_SUB:  alu_out = {{DATA_W{1'b0}}, y_q - bus};
      OP_AND:  alu_out = {{DATA_W{1'b0}}, y_q & bus};
      OP_OR:   alu_out = {{DATA_W{1'b0}}, y_q | bus};
      OP_SHL:  alu_out = {{DATA_W{1'b0}}, y_q << bus[SH_W-1:0]};
      OP_SHR:  alu_out = {{DATA_W{1'b0}}, y_q >> bus[SH_W-1:0]};
      OP_MUL:  alu_out = mul_a * mul_b;
      OP_NOT:  alu_out = {{DATA_W{1'b0}}, ~bus};
      OP_ADDI: alu_out = {{DATA_W{1'b0}}, y_q + bus};
      default: alu_out = '0;
    endcase
  end

  // Next-state logic plus the done/err pulses of the final micro-step.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_T1;
      S_T1: begin
        if (illegal) begin
          state_nx = S_IDLE;
          done     = 1'b1;
          err      = 1'b1;
        end else begin
          state_nx = S_T2;
        end
      end
      S_T2: state_nx = S_T3;
      S_T3: begin
        if (is_mul) begin
          state_nx = S_T4;
        end else begin
          state_nx = S_IDLE;
          done     = 1'b1;
        end
      end
      S_T4: begin
        state_nx = S_IDLE;
        done     = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer state register. The instruction fields are captured when a start is accepted.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      imm_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        op_q  <= op;
        ra_q  <= ra;
        rb_q  <= rb;
        rc_q  <= rc;
        imm_q <= imm;
      end
    end
  end

  // Datapath registers: host loads while idle, then one register transfer per micro-step.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      y_q    <= '0;
      z_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (state == S_IDLE && ld_en && ld_ok) regs[ld_addr] <= ld_data;
      case (state)
        S_T1: if (!illegal) y_q <= bus;
        S_T2: z_q <= alu_out;
        S_T3: begin
          if (is_mul) begin
            lo_q <= bus;
          end else begin
            if (wb_ok) regs[ra_q] <= bus;
            flag_z <= (bus == '0);
            flag_n <= bus[DATA_W-1];
          end
        end
        S_T4: begin
          hi_q   <= bus;
          flag_z <= (z_q == '0);
          flag_n <= z_q[2*DATA_W-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Testbench for bus_datapath_seq. It runs directed and random instructions against a
// behavioural register-file model. Expected results are queued at issue time, and a
// monitor checks them when done is pulsed.
module tb_bus_datapath_seq;

  logic        clock, clear, start;
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic [31:0] imm;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data, hi_q, lo_q, bus_q;
  logic        busy, done, err, flag_z, flag_n;

  bus_datapath_seq dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .imm(imm), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .hi_q(hi_q), .lo_q(lo_q), .busy(busy), .done(done), .err(err),
    .flag_z(flag_z), .flag_n(flag_n), .bus_q(bus_q)
  );

`ifdef R0_ZERO_EN
  localparam bit M_R0 = 1'b1;
`else
  localparam bit M_R0 = 1'b0;
`endif

  typedef struct {
    logic        err;
    int          lat;
    logic [3:0]  ra;
    logic [31:0] val, hi, lo;
    logic        z, n;
  } item_t;

  item_t exp_q[$];
  int tot = 0, bad = 0, done_cnt = 0;

  // reference model state
  logic [31:0] m_r[16];
  logic [31:0] m_hi, m_lo;
  logic        m_z, m_n;

  // the monitor borrows rd_addr to check the destination after each done
  logic       mon_sel = 1'b0;
  logic [3:0] mon_addr = '0, drv_rd_addr = '0;
  assign rd_addr = mon_sel ? mon_addr : drv_rd_addr;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    return (M_R0 && a == 4'd0) ? 32'd0 : m_r[a];
  endfunction

  task automatic m_wr(input logic [3:0] a, input logic [31:0] d);
    if (!(M_R0 && a == 4'd0)) m_r[a] = d;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    m_hi = 0; m_lo = 0; m_z = 0; m_n = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tot++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_load(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    ld_en = 1; ld_addr = a; ld_data = d;
    m_wr(a, d);
    @(posedge clock); #1;
    ld_en = 0;
  endtask

  task automatic chk_reg(input logic [3:0] a);
    @(negedge clock);
    drv_rd_addr = a;
    #1;
    chk($sformatf("reg_r%0d", a), rd_data, m_rd(a));
  endtask

  task automatic run_op(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [31:0] im, input bit ld,
                        input logic [3:0] la, input logic [31:0] ldd, input bit noise);
    item_t it;
    logic [31:0] x, yv, res;
    logic [63:0] pu;
    longint p;
    logic [3:0] naddr;
    int d0;
    bit seen;
    naddr = 0;
    @(negedge clock);
    op = o; ra = a; rb = b; rc = c; imm = im; start = 1;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    if (ld) m_wr(la, ldd);
    // model: Ra <- Rb op (Rc or imm)
    x  = m_rd(b);
    yv = (o == 5'd8) ? im : m_rd(c);
    it.err = 0; it.lat = 3; res = 0;
    case (o)
      5'd0: res = x + yv;
      5'd1: res = x - yv;
      5'd2: res = x & yv;
      5'd3: res = x | yv;
      5'd4: res = x << (yv % 32);
      5'd5: res = x >> (yv % 32);
      5'd7: res = ~yv;
      5'd8: res = x + yv;
      5'd6: begin
        p  = longint'($signed(x)) * longint'($signed(yv));
        pu = p;
        m_lo = pu[31:0]; m_hi = pu[63:32];
        m_z = (pu == 64'd0); m_n = pu[63];
        it.lat = 4;
      end
      default: begin it.err = 1; it.lat = 1; end
    endcase
    if (!it.err && o != 5'd6) begin
      m_wr(a, res);
      m_z = (res == 32'd0);
      m_n = res[31];
    end
    it.ra = a; it.val = m_rd(a); it.hi = m_hi; it.lo = m_lo; it.z = m_z; it.n = m_n;
    exp_q.push_back(it);
    d0 = done_cnt;
    @(posedge clock); #1;
    start = 0; ld_en = 0;
    if (noise) begin
      // both of these land while busy and must be dropped
      start = 1; op = 5'($urandom_range(0, 8)); ra = 4'($urandom_range(0, 15));
      ld_en = 1; naddr = 4'($urandom_range(0, 15)); ld_addr = naddr; ld_data = $urandom;
      @(posedge clock); #1;
      start = 0; ld_en = 0;
    end
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      if (done_cnt != d0) seen = 1;
      else @(negedge clock);
    end
    if (done_cnt != d0) seen = 1;
    tot++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: op %0d got no done, expected done within 12 cycles", o);
    end
    @(negedge clock);
    @(negedge clock);
    if (noise) chk_reg(naddr);
  endtask

  task automatic reset_checks();
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_hi", hi_q, 32'd0);
    chk("rst_lo", lo_q, 32'd0);
    chk("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);
    chk("rst_bus", bus_q, 32'd0);
    for (int i = 0; i < 16; i++) chk_reg(4'(i));
  endtask

  // ---------------- scoreboard monitor ----------------
  int busy_cnt = 0;
  bit chk_pend = 0;
  item_t cur;

  always @(negedge clock) begin
    if (clear) begin
      busy_cnt = 0;
      chk_pend = 0;
      mon_sel  = 0;
    end else begin
      if (chk_pend) begin
        chk("wb_reg", rd_data, cur.val);
        chk("wb_hi", hi_q, cur.hi);
        chk("wb_lo", lo_q, cur.lo);
        chk("wb_flags", {30'd0, flag_z, flag_n}, {30'd0, cur.z, cur.n});
        chk_pend = 0;
        mon_sel  = 0;
      end
      if (!busy) chk("idle_bus", bus_q, 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          tot++; bad++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          cur = exp_q.pop_front();
          chk("err", {31'd0, err}, {31'd0, cur.err});
          chk("busy_cycles", busy_cnt, cur.lat);
          mon_addr = cur.ra;
          mon_sel  = 1;
          chk_pend = 1;
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    start = 0; op = 0; ra = 0; rb = 0; rc = 0; imm = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    m_reset();
    clear = 1;
    repeat (2) @(posedge clock);
    #1 clear = 0;
    reset_checks();

    // basic add
    host_load(1, 32'd5); host_load(2, 32'd7);
    run_op(0, 3, 1, 2, 0, 0, 0, 0, 0);
    // wrap and subtract
    host_load(1, 32'hFFFF_FFFF); host_load(2, 32'd1);
    run_op(0, 4, 1, 2, 0, 0, 0, 0, 0);
    run_op(1, 9, 2, 1, 0, 0, 0, 0, 0);
    // signed multiply, destination untouched
    host_load(5, 32'hFFFF_FFFD); host_load(6, 32'd4); host_load(10, 32'h1234_5678);
    run_op(6, 10, 5, 6, 0, 0, 0, 0, 0);
    // shift amount uses low bits only; addi with R0
    host_load(7, 32'h8000_0000); host_load(8, 32'd33);
    run_op(5, 11, 7, 8, 0, 0, 0, 0, 0);
    run_op(4, 12, 7, 8, 0, 0, 0, 0, 0);
    host_load(0, 32'd9);
    chk_reg(0);
    run_op(8, 12, 0, 0, 32'h10, 0, 0, 0, 0);
    run_op(7, 13, 0, 12, 0, 0, 0, 0, 0);
    // illegal op and activity while busy
    run_op(20, 3, 1, 2, 0, 0, 0, 0, 1);
    run_op(0, 3, 1, 2, 0, 0, 0, 0, 1);
    run_op(6, 2, 5, 5, 0, 0, 0, 0, 1);
    // load in the same cycle as start; full aliasing
    run_op(0, 13, 14, 14, 0, 1, 14, 32'h0000_0021, 0);
    run_op(0, 3, 3, 3, 0, 0, 0, 0, 0);
    run_op(2, 6, 6, 6, 0, 1, 6, 32'hF0F0_00FF, 0);

    // abort an ADD in T2
    @(negedge clock);
    op = 0; ra = 15; rb = 1; rc = 2; start = 1;
    @(posedge clock); #1 start = 0;
    @(posedge clock); #1 clear = 1;
    @(posedge clock); #1 clear = 0;
    m_reset();
    reset_checks();
    host_load(1, 32'd40); host_load(2, 32'd2);
    run_op(0, 15, 1, 2, 0, 0, 0, 0, 0);

    // random instructions
    for (int n = 0; n < 70; n++) begin
      logic [4:0] ro;
      logic [31:0] v;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: v = 32'd0;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h8000_0000;
          default: v = $urandom;
        endcase
        host_load(4'($urandom_range(0, 15)), v);
      end
      ro = ($urandom_range(0, 9) == 9) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
      run_op(ro, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 2) == 0),
             4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 4) == 0));
    end

    repeat (4) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) chk_reg(4'(i));
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
- Parametrised successor to the single-bus CPU datapath: register file, Y/Z/HI/LO registers, ALU and one shared internal bus.
- Adds an internal micro-step sequencer that runs three-operand ALU instructions (Ra <- Rb op Rc/imm) with a start/busy/done handshake, so per-step bus control signals are no longer needed.
- Register file width and depth are generic.
- Sits between the control unit and memory; the host loads and reads registers through dedicated ports.

Parameters:
- DATA_W, 32, datapath width in bits (power of two, >= 8).
- NUM_REGS, 16, number of general registers (power of two, >= 4).
- REG_AW, 4, register address width, = log2(NUM_REGS).

Ports:
- clock  in  1  sole clock, rising edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  5  operation code.
- ra  in  REG_AW  destination register.
- rb  in  REG_AW  first source register.
- rc  in  REG_AW  second source register.
- imm  in  DATA_W  immediate for ADDI.
- ld_en  in  1  host register write.
- ld_addr  in  REG_AW  host write address.
- ld_data  in  DATA_W  host write data.
- rd_addr  in  REG_AW  host read address.
- rd_data  out  DATA_W  combinational R[rd_addr].
- hi_q  out  DATA_W  HI register.
- lo_q  out  DATA_W  LO register.
- busy  out  1  sequencer not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done on an illegal op.
- flag_z  out  1  result == 0, from the last writeback.
- flag_n  out  1  result MSB, from the last writeback.
- bus_q  out  DATA_W  current internal bus value (debug).

Behaviour:
- Reset (clear=1 at a rising edge): all registers, Y, Z, HI, LO = 0; state IDLE; busy/done/err/flag_z/flag_n = 0.
  - clear mid-operation aborts the operation: no writeback, no done.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 MUL (signed), 7 NOT (of Rc; Y ignored), 8 ADDI (Rb + imm).
  - 9-31 illegal.
- Arithmetic and width:
  - ADD/SUB/ADDI wrap modulo 2^DATA_W.
  - Shift amount = bus[log2(DATA_W)-1:0]; upper bits ignored.
  - MUL produces a 2*DATA_W result: Zlow -> LO, Zhigh -> HI; Ra is not written.
- Sequencer states: IDLE -> T1 -> T2 -> T3 [-> T4 for MUL] -> IDLE.
  - IDLE: when start=1, latch op/ra/rb/rc/imm; next state T1.
  - T1: bus = R[rb]; Y <= bus.
  - T2: bus = R[rc] (imm for ADDI); Z <= ALU(Y, bus), 2*DATA_W wide.
  - T3 (non-MUL): bus = Zlow; R[ra] <= bus; update flags; done pulse.
  - T3 (MUL): bus = Zlow; LO <= bus.
  - T4 (MUL only): bus = Zhigh; HI <= bus; flags from the full 2*DATA_W product; done pulse.
  - Illegal op: T1 goes straight to IDLE; done=1 and err=1 that cycle; no state is changed.
- Timing, start sampled at edge N:
  - busy = 1 during cycles N+1 .. N+3 (MUL: .. N+4).
  - done is asserted combinationally during the final state cycle.
  - The written value is visible on rd_data from cycle N+4 (MUL: HI/LO from N+5).
- Handshake:
  - start while busy is ignored and is not queued.
  - done never coincides with the acceptance of a new start.
  - The earliest back-to-back start is in the cycle after done.
- Host load port:
  - ld_en is honoured only when busy=0.
  - ld_en while busy is dropped.
  - ld_en and start in the same IDLE cycle: the load commits at that edge, and the operation reads the loaded value in T1/T2.
- Operand aliasing: ra == rb == rc is legal; sources are read before the writeback.
- bus_q is 0 in IDLE.

Optional Feature:
- Macro R0_ZERO_EN.
- Defined: register 0 reads as 0 on rd_data and on the bus; writes to R0 from the sequencer or the host are discarded. Flags are still updated from the computed result.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset and load: clear, then load R1=5, R2=7; start ADD ra=3 rb=1 rc=2 -> busy for 3 cycles, done in the 3rd, R3=12, flag_z=0, flag_n=0.
- Wrap: R1=0xFFFFFFFF, R2=1, ADD ra=4 -> R4=0, flag_z=1. SUB R2-R1 -> 2.
- MUL: R5=-3 (0xFFFFFFFD), R6=4; MUL -> LO=0xFFFFFFF4, HI=0xFFFFFFFF, destination register unchanged, done after 4 busy cycles, flag_n=1.
- Shift/ADDI: R7=0x80000000, R8=33; SHR -> 0x40000000 (amount 1). ADDI rb=0 imm=0x10 with R0=9 -> 0x19 (with R0_ZERO_EN: 0x10, and R0 still reads 0 after a host load of 9).
- Handshake/illegal: start op=20 -> done=1 and err=1 in cycle N+1, registers unchanged. start pulsed while busy and ld_en while busy -> both ignored.
- Abort: clear asserted during T2 of ADD -> no done, all registers 0, next start executes normally.
